butterfly_pipe: RTL

// - Radix-2 DIT butterfly stage that consumes the memory stage's even/odd/twiddle read outputs
//   and produces top/bot results for write-back through the memory stage's top/bot write muxes.
// - The memory stage presents even and odd samples one at a time through its demux.

---
 rtl/fft_pkg.sv | 50 +++++
 rtl/fft_cmul_pipe.sv | 92 +++++++++
 rtl/butterfly_pipe.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared definitions for the radix-2 butterfly datapath.
//               - Default Q-format (I integer bits incl. sign, F fraction bits)
//               - word_w(): word width helper, W = I + F
//               - sat_w():  signed saturation of a wide value to w bits
//               - c_ONE:    1.0 in the default Q-format
//               - pair_state_t: states of the even/odd pairing FSM
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int c_I_DEF = 4;
    localparam int c_F_DEF = 12;
    localparam int c_ONE   = 1 << c_F_DEF;

    // Working width for saturation; every intermediate passed to sat_w must
    // fit here, which bounds W to at most 31 bits.
    localparam int c_SAT_W = 64;

    typedef enum logic [0:0] {
        ST_EMPTY     = 1'b0,
        ST_HAVE_EVEN = 1'b1
    } pair_state_t;

    function automatic int word_w(input int i, input int f);
        return i + f;
    endfunction

    // Clamp x into [-2^(w-1), 2^(w-1)-1]; the caller truncates to w bits.
    function automatic logic signed [c_SAT_W-1:0] sat_w(
        input logic signed [c_SAT_W-1:0] x,
        input int                        w
    );
        logic signed [c_SAT_W-1:0] hi;
        logic signed [c_SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_cmul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fft_cmul_pipe
// Description : Two-stage pipelined complex multiply t = b * twi.
//               Stage 1 registers the four 2W-bit partial products, stage 2
//               combines them, truncates (floor) by F and saturates to W.
// Ports       : clk, rst (async, active-low), i_clr (sync valid clear)
//               i_vld, i_b_re/im, i_twi_re/im  -> operands
//               o_t_re/im, o_vld               -> product, two edges later
// Revision    : 1.0 - initial release
// ============================================================================
module fft_cmul_pipe
    import fft_pkg::*;
#(
    parameter  int I = c_I_DEF,
    parameter  int F = c_F_DEF,
    localparam int W = word_w(I, F)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_vld,
    input  logic [W-1:0] i_b_re,
    input  logic [W-1:0] i_b_im,
    input  logic [W-1:0] i_twi_re,
    input  logic [W-1:0] i_twi_im,
    output logic [W-1:0] o_t_re,
    output logic [W-1:0] o_t_im,
    output logic         o_vld
);

    // Operands sign-extended to the product width so the multiply is
    // evaluated at full precision without relying on context extension.
    logic signed [2*W-1:0] w_br;
    logic signed [2*W-1:0] w_bi;
    logic signed [2*W-1:0] w_wr;
    logic signed [2*W-1:0] w_wi;

    assign w_br = {{W{i_b_re[W-1]}},   i_b_re};
    assign w_bi = {{W{i_b_im[W-1]}},   i_b_im};
    assign w_wr = {{W{i_twi_re[W-1]}}, i_twi_re};
    assign w_wi = {{W{i_twi_im[W-1]}}, i_twi_im};

    logic signed [2*W-1:0] r_p_rr;
    logic signed [2*W-1:0] r_p_ii;
    logic signed [2*W-1:0] r_p_ri;
    logic signed [2*W-1:0] r_p_ir;
    logic                  r_v1;
    logic [W-1:0]          r_t_re;
    logic [W-1:0]          r_t_im;
    logic                  r_v2;

    // One guard bit for the add/sub of two full-width products.
    logic signed [2*W:0] w_re_full;
    logic signed [2*W:0] w_im_full;
    logic signed [2*W:0] w_re_sh;
    logic signed [2*W:0] w_im_sh;

    assign w_re_full = {r_p_rr[2*W-1], r_p_rr} - {r_p_ii[2*W-1], r_p_ii};
    assign w_im_full = {r_p_ri[2*W-1], r_p_ri} + {r_p_ir[2*W-1], r_p_ir};
    // Arithmetic shift rounds toward minus infinity (floor truncation).
    assign w_re_sh   = w_re_full >>> F;
    assign w_im_sh   = w_im_full >>> F;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ri <= '0;
            r_p_ir <= '0;
            r_v1   <= 1'b0;
            r_t_re <= '0;
            r_t_im <= '0;
            r_v2   <= 1'b0;
        end else begin
            r_p_rr <= w_br * w_wr;
            r_p_ii <= w_bi * w_wi;
            r_p_ri <= w_br * w_wi;
            r_p_ir <= w_bi * w_wr;
            r_v1   <= i_vld & ~i_clr;
            r_t_re <= W'(sat_w(c_SAT_W'(w_re_sh), W));
            r_t_im <= W'(sat_w(c_SAT_W'(w_im_sh), W));
            r_v2   <= r_v1 & ~i_clr;
        end
    end

    assign o_t_re = r_t_re;
    assign o_t_im = r_t_im;
    assign o_vld  = r_v2;

endmodule
`default_nettype wire

// File: rtl/butterfly_pipe.sv
`default_nettype none
// ============================================================================
// Module      : butterfly_pipe
// Description : Radix-2 DIT butterfly. Pairs even and odd samples arriving
//               one at a time, computes t = odd*twi, top = even+t and
//               bot = even-t through a 4-register pipeline (no stall).
// Ports       : clk, rst (async, active-low), i_clr (sync clear)
//               i_even_vld, i_even_re/im          -> even sample
//               i_odd_vld, i_odd_re/im, i_twi_re/im -> odd sample + twiddle
//               o_top_re/im, o_bot_re/im, o_vld   -> results, 1-cycle strobe
//               o_err                             -> sticky orphan-odd flag
// Revision    : 1.0 - initial release
// ============================================================================
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter  int I     = c_I_DEF,
    parameter  int F     = c_F_DEF,
    parameter  int SCALE = 0,
    localparam int W     = word_w(I, F)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_even_vld,
    input  logic         i_odd_vld,
    input  logic [W-1:0] i_even_re,
    input  logic [W-1:0] i_even_im,
    input  logic [W-1:0] i_odd_re,
    input  logic [W-1:0] i_odd_im,
    input  logic [W-1:0] i_twi_re,
    input  logic [W-1:0] i_twi_im,
    output logic [W-1:0] o_top_re,
    output logic [W-1:0] o_top_im,
    output logic [W-1:0] o_bot_re,
    output logic [W-1:0] o_bot_im,
    output logic         o_vld,
    output logic         o_err
);

    // ------------------------------------------------------------------
    // Pairing FSM
    // ------------------------------------------------------------------
    pair_state_t r_state;
    pair_state_t w_state_nx;
    logic        w_fire;         // pair forms this cycle
    logic        w_use_in_even;  // pair takes even from the inputs, not the hold reg
    logic        w_latch;        // capture input even into the hold reg
    logic        w_err_set;

    always_comb begin
        w_state_nx    = r_state;
        w_fire        = 1'b0;
        w_use_in_even = 1'b0;
        w_latch       = 1'b0;
        w_err_set     = 1'b0;
        if (i_clr) begin
            w_state_nx = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (i_odd_vld) begin
                        if (i_even_vld) begin
                            w_fire        = 1'b1;
                            w_use_in_even = 1'b1;
                        end else begin
                            w_err_set = 1'b1;
                        end
                    end else if (i_even_vld) begin
                        w_latch    = 1'b1;
                        w_state_nx = ST_HAVE_EVEN;
                    end
                end
                ST_HAVE_EVEN: begin
                    if (i_odd_vld) begin
                        w_fire        = 1'b1;
                        w_use_in_even = i_even_vld;
                        w_state_nx    = ST_EMPTY;
                    end else if (i_even_vld) begin
                        w_latch = 1'b1;
                    end
                end
                default: w_state_nx = ST_EMPTY;
            endcase
        end
    end

    logic [W-1:0] r_hold_re;
    logic [W-1:0] r_hold_im;
    logic         r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_EMPTY;
            r_hold_re <= '0;
            r_hold_im <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_latch) begin
                r_hold_re <= i_even_re;
                r_hold_im <= i_even_im;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pair registers (edge k) and even delay line (edges k+1, k+2) that
    // keeps the even sample aligned with the two-stage multiplier.
    // ------------------------------------------------------------------
    logic [W-1:0] r_pe_re;
    logic [W-1:0] r_pe_im;
    logic [W-1:0] r_po_re;
    logic [W-1:0] r_po_im;
    logic [W-1:0] r_pt_re;
    logic [W-1:0] r_pt_im;
    logic         r_v0;
    logic [W-1:0] r_ev1_re;
    logic [W-1:0] r_ev1_im;
    logic [W-1:0] r_ev2_re;
    logic [W-1:0] r_ev2_im;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pe_re  <= '0;
            r_pe_im  <= '0;
            r_po_re  <= '0;
            r_po_im  <= '0;
            r_pt_re  <= '0;
            r_pt_im  <= '0;
            r_v0     <= 1'b0;
            r_ev1_re <= '0;
            r_ev1_im <= '0;
            r_ev2_re <= '0;
            r_ev2_im <= '0;
        end else begin
            r_v0 <= w_fire;
            if (w_fire) begin
                r_pe_re <= w_use_in_even ? i_even_re : r_hold_re;
                r_pe_im <= w_use_in_even ? i_even_im : r_hold_im;
                r_po_re <= i_odd_re;
                r_po_im <= i_odd_im;
                r_pt_re <= i_twi_re;
                r_pt_im <= i_twi_im;
            end
            r_ev1_re <= r_pe_re;
            r_ev1_im <= r_pe_im;
            r_ev2_re <= r_ev1_re;
            r_ev2_im <= r_ev1_im;
        end
    end

    // ------------------------------------------------------------------
    // Complex multiply (edges k+1, k+2)
    // ------------------------------------------------------------------
    logic [W-1:0] w_t_re;
    logic [W-1:0] w_t_im;
    logic         w_t_vld;

    fft_cmul_pipe #(
        .I (I),
        .F (F)
    ) u_cmul (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (i_clr),
        .i_vld    (r_v0),
        .i_b_re   (r_po_re),
        .i_b_im   (r_po_im),
        .i_twi_re (r_pt_re),
        .i_twi_im (r_pt_im),
        .o_t_re   (w_t_re),
        .o_t_im   (w_t_im),
        .o_vld    (w_t_vld)
    );

    // ------------------------------------------------------------------
    // Add/sub, optional halving, saturation (edge k+3)
    // ------------------------------------------------------------------
    logic signed [W:0] w_sum_re;
    logic signed [W:0] w_sum_im;
    logic signed [W:0] w_dif_re;
    logic signed [W:0] w_dif_im;
    logic signed [W:0] w_sum_re_sc;
    logic signed [W:0] w_sum_im_sc;
    logic signed [W:0] w_dif_re_sc;
    logic signed [W:0] w_dif_im_sc;

    assign w_sum_re = {r_ev2_re[W-1], r_ev2_re} + {w_t_re[W-1], w_t_re};
    assign w_sum_im = {r_ev2_im[W-1], r_ev2_im} + {w_t_im[W-1], w_t_im};
    assign w_dif_re = {r_ev2_re[W-1], r_ev2_re} - {w_t_re[W-1], w_t_re};
    assign w_dif_im = {r_ev2_im[W-1], r_ev2_im} - {w_t_im[W-1], w_t_im};

    generate
        if (SCALE != 0) begin : g_scale_half
            assign w_sum_re_sc = w_sum_re >>> 1;
            assign w_sum_im_sc = w_sum_im >>> 1;
            assign w_dif_re_sc = w_dif_re >>> 1;
            assign w_dif_im_sc = w_dif_im >>> 1;
        end else begin : g_scale_none
            assign w_sum_re_sc = w_sum_re;
            assign w_sum_im_sc = w_sum_im;
            assign w_dif_re_sc = w_dif_re;
            assign w_dif_im_sc = w_dif_im;
        end
    endgenerate

    logic [W-1:0] r_top_re;
    logic [W-1:0] r_top_im;
    logic [W-1:0] r_bot_re;
    logic [W-1:0] r_bot_im;
    logic         r_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_top_re <= '0;
            r_top_im <= '0;
            r_bot_re <= '0;
            r_bot_im <= '0;
            r_vld    <= 1'b0;
        end else begin
            r_vld <= w_t_vld & ~i_clr;
            // Outputs only move together with the strobe so they hold
            // their last value whenever o_vld is low.
            if (w_t_vld && !i_clr) begin
                r_top_re <= W'(sat_w(c_SAT_W'(w_sum_re_sc), W));
                r_top_im <= W'(sat_w(c_SAT_W'(w_sum_im_sc), W));
                r_bot_re <= W'(sat_w(c_SAT_W'(w_dif_re_sc), W));
                r_bot_im <= W'(sat_w(c_SAT_W'(w_dif_im_sc), W));
            end
        end
    end

    assign o_top_re = r_top_re;
    assign o_top_im = r_top_im;
    assign o_bot_re = r_bot_re;
    assign o_bot_im = r_bot_im;
    assign o_vld    = r_vld;
    assign o_err    = r_err;

endmodule
`default_nettype wire
